vram_writer: RTL

Block-transfer engine that generates the VRAM write stream consumed by the foreground and background pattern/object memories. The CPU-side control logic programs a source base, VRAM destination and length, then pulses `start`. The engine reads bytes from a synchronous source memory and emits `data`/`address`/`we` beats into VRAM, writing only while the video timing asserts `writable`. A byte fetched just before `writable` drops is held and written once the window reopens.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/vram_skid_m.sv | 24 ++
 rtl/vram_writer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM writer state encoding and transfer limits.
package gpu_pkg;

  localparam int LEN_W    = 9;
  localparam int MAX_XFER = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } vram_writer_state_t;

endpackage

// File: rtl/vram_skid_m.sv
// One-entry hold register for a source byte that arrives while VRAM is not writable.
module vram_skid_m (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic [7:0] din,
  output logic       valid,
  output logic [7:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_writer.sv
// Block-transfer engine: copies len bytes from a synchronous source memory into VRAM,
// writing only while the video timing opens the write window.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 11
`endif

module vram_writer
  import gpu_pkg::*;
#(
  parameter int SRC_W = 16,
  parameter int VA_W  = `VRAM_ADDR_WIDTH,
  parameter int LEN_W = gpu_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writable,
  input  logic             start,
  input  logic [SRC_W-1:0] src_base,
  input  logic [VA_W-1:0]  dst_base,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [SRC_W-1:0] src_addr,
  output logic             src_rd,
  input  logic [7:0]       src_data,
  output logic [7:0]       vram_data,
  output logic [VA_W-1:0]  vram_address,
  output logic             vram_we
);

  vram_writer_state_t state, state_nx;

  logic [SRC_W-1:0] src_base_q;
  logic [VA_W-1:0]  dst_base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] wr_cnt;
  logic             rd_pend;

  logic             skid_valid;
  logic [7:0]       skid_data;
  logic             skid_load;
  logic             skid_drain;

  logic             rd_go;
  logic             wr_go;
  logic             last_wr;
  logic             running;

  vram_skid_m u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .din   (src_data),
    .valid (skid_valid),
    .dout  (skid_data)
  );

  // Reads and writes are gated by writable in the same cycle, so a closing window
  // stops traffic immediately and a reopening one resumes it without a bubble.
  always_comb begin
    running    = rst && (state == RUN);
    rd_go      = running && writable && (rd_cnt < len_q);
    wr_go      = running && writable && (skid_valid || rd_pend);
    skid_drain = wr_go && skid_valid;
    skid_load  = running && !writable && rd_pend;
    last_wr    = wr_go && ((wr_cnt + LEN_W'(1)) == len_q);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len != '0) ? RUN : FINISH;
        end
      end
      RUN: begin
        if (last_wr) begin
          state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      rd_pend    <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= rd_go;
      if ((state == IDLE) && start) begin
        src_base_q <= src_base;
        dst_base_q <= dst_base;
        len_q      <= (len > LEN_W'(MAX_XFER)) ? LEN_W'(MAX_XFER) : len;
        rd_cnt     <= '0;
        wr_cnt     <= '0;
      end else begin
        if (rd_go) begin
          rd_cnt <= rd_cnt + LEN_W'(1);
        end
        if (wr_go) begin
          wr_cnt <= wr_cnt + LEN_W'(1);
        end
      end
    end
  end

  // A held byte is always older than any byte returned from the source.
  always_comb begin
    busy         = (state == RUN);
    done         = rst && (state == FINISH);
    src_rd       = rd_go;
    src_addr     = src_base_q + SRC_W'(rd_cnt);
    vram_we      = wr_go;
    vram_address = dst_base_q + VA_W'(wr_cnt);
    vram_data    = '0;
    if (wr_go) begin
      vram_data = skid_valid ? skid_data : src_data;
    end
  end

endmodule
